// File: rtl/bus8_arbiter.sv
// Round-robin arbiter for four requesters sharing the 8-bit bus buffer input.
// Optional burst limit per grant is enabled by defining BUS8_ARB_BURST_LIMIT_EN.
module bus8_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NREQ-1:0]     REQ,
    input  logic [8*NREQ-1:0]   DIN,
    output logic [NREQ-1:0]     GNT,
    output logic [7:0]          BUS_D,
    output logic                BUS_V,
    output logic                BUSY
);

    if (NREQ != 4) begin : g_bad_nreq
        $error("bus8_arbiter supports NREQ=4 only");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("bus8_arbiter MAX_BURST must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      ptr, ptr_nxt;
    logic [1:0]      owner, owner_nxt;
    logic [1:0]      win, cand;
    logic            win_found;
    logic [NREQ-1:0] gnt_nxt;
    logic [7:0]      bus_d_nxt;
    logic            bus_v_nxt;
    logic [7:0]      owner_byte;

`ifdef BUS8_ARB_BURST_LIMIT_EN
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    logic [7:0] cnt, cnt_nxt;
`endif

    assign owner_byte = DIN[{owner, 3'b000} +: 8];
    assign BUSY       = (state != IDLE);

    // Rotating priority search starting at ptr; the first hit wins.
    always_comb begin
        win       = ptr;
        win_found = 1'b0;
        cand      = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!win_found && REQ[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        gnt_nxt   = GNT;
        bus_d_nxt = BUS_D;
        bus_v_nxt = 1'b0;
`ifdef BUS8_ARB_BURST_LIMIT_EN
        cnt_nxt   = cnt;
`endif
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                    owner_nxt    = win;
                    state_nxt    = OWN;
`ifdef BUS8_ARB_BURST_LIMIT_EN
                    cnt_nxt      = 8'd0;
`endif
                end
            end
            OWN: begin
                if (REQ[owner]) begin
                    bus_d_nxt = owner_byte;
                    bus_v_nxt = 1'b1;
`ifdef BUS8_ARB_BURST_LIMIT_EN
                    cnt_nxt   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                    // Final byte of a maximal burst: transfer it and preempt.
                    if (cnt == BURST_LAST) begin
                        gnt_nxt   = '0;
                        ptr_nxt   = owner + 2'd1;
                        state_nxt = GAP;
                    end
`endif
                end else begin
                    gnt_nxt   = '0;
                    ptr_nxt   = owner + 2'd1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            ptr   <= 2'd0;
            owner <= 2'd0;
            GNT   <= '0;
            BUS_D <= 8'h00;
            BUS_V <= 1'b0;
`ifdef BUS8_ARB_BURST_LIMIT_EN
            cnt   <= 8'd0;
`endif
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            GNT   <= gnt_nxt;
            BUS_D <= bus_d_nxt;
            BUS_V <= bus_v_nxt;
`ifdef BUS8_ARB_BURST_LIMIT_EN
            cnt   <= cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_bus8_arbiter.sv
// Self-checking bench for bus8_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_bus8_arbiter;

    localparam int TB_BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [7:0]  bus_d;
    logic        bus_v;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    bus8_arbiter #(.NREQ(4), .MAX_BURST(TB_BURST)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .REQ   (req),
        .DIN   (din),
        .GNT   (gnt),
        .BUS_D (bus_d),
        .BUS_V (bus_v),
        .BUSY  (busy)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus, how many dead cycles remain, and
    // where the next round-robin search begins.
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_gap   = 0;
    int         m_run   = 0;
    logic [7:0] m_d     = 8'h00;
    logic       m_v     = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_gap   = 0;
            m_run   = 0;
            m_d     = 8'h00;
            m_v     = 1'b0;
        end else begin
            m_v = 1'b0;
            if (m_owner >= 0) begin
                if (req[m_owner]) begin
                    m_d = din[8*m_owner +: 8];
                    m_v = 1'b1;
                    m_run++;
`ifdef BUS8_ARB_BURST_LIMIT_EN
                    if (m_run == TB_BURST) begin
                        m_ptr   = (m_owner + 1) % 4;
                        m_owner = -1;
                        m_gap   = 1;
                    end
`endif
                end else begin
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = -1;
                    m_gap   = 1;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        m_run   = 0;
                    end
                end
            end
        end
    end

    logic [13:0] dut_vec;
    logic [13:0] exp_vec;
    assign dut_vec = {gnt, bus_v, bus_d, busy};
    always_comb begin
        exp_vec = {4'b0000, m_v, m_d, (m_owner >= 0 || m_gap > 0)};
        if (m_owner >= 0) exp_vec[13:10] = 4'(4'b0001 << m_owner);
    end

    // Advance one clock; outputs are then sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        din   = 32'h0;
        tick();
        vectors++;
        if (dut_vec !== 14'h0000) begin
            miscompares++;
            $display("FAIL reset_state: got %h, expected 0000", dut_vec);
        end
        rst_n = 1'b1;
        req   = 4'b0001;
        din   = 32'h000000A5;
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_pre_xfer c%0d: got %h, expected %h", c, dut_vec, exp_vec);
            end
        end
        rst_n = 1'b0;
        tick();
        vectors++;
        if (dut_vec !== 14'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_xfer: got %h, expected 0000", dut_vec);
        end
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || bus_v !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ptr_restart: gnt=%b v=%b, expected gnt=0001 v=0", gnt, bus_v);
        end
        req = 4'b0000;
        tick();
        tick();
        vectors++;
        if (dut_vec !== exp_vec || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_back_idle: got %h, expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_b;
        req = 4'b0100;
        din = 32'h003C0000;
        tick();
        vectors++;
        if (gnt !== 4'b0100 || bus_v !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant: gnt=%b v=%b busy=%b, expected 0100/0/1", gnt, bus_v, busy);
        end
        for (int b = 0; b < 3; b++) begin
            exp_b      = 8'h3C + 8'(b);
            din[23:16] = exp_b;
            tick();
            vectors++;
            if (gnt !== 4'b0100 || bus_v !== 1'b1 || bus_d !== exp_b) begin
                miscompares++;
                $display("FAIL single_byte%0d: gnt=%b v=%b d=%h, expected 0100/1/%h", b, gnt, bus_v, bus_d, exp_b);
            end
        end
        req = 4'b0000;
        din = 32'hFFFFFFFF;
        tick();
        vectors++;
        if (gnt !== 4'b0000 || bus_v !== 1'b0 || bus_d !== 8'h3E || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_gap: gnt=%b v=%b d=%h busy=%b, expected 0000/0/3e/1", gnt, bus_v, bus_d, busy);
        end
        tick();
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || bus_d !== 8'h3E) begin
            miscompares++;
            $display("FAIL single_idle: gnt=%b busy=%b d=%h, expected 0000/0/3e", gnt, busy, bus_d);
        end
    endtask

    task automatic test_contention();
        int         idle;
        logic [3:0] exp_g;
        logic [7:0] exp_b;
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        din   = 32'h44332211;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'(4'b0001 << (g % 4));
            exp_b = 8'(8'h11 * ((g % 4) + 1));
            idle  = 0;
            while (gnt === 4'b0000 && idle < 8) begin
                tick();
                idle++;
            end
            vectors++;
            if (gnt !== exp_g) begin
                miscompares++;
                $display("FAIL contention_order g%0d: got %b, expected %b", g, gnt, exp_g);
            end
            if (g > 0) begin
                vectors++;
                if (idle != 2) begin
                    miscompares++;
                    $display("FAIL contention_turnaround g%0d: got %0d, expected 2", g, idle);
                end
            end
            tick();
            vectors++;
            if (bus_v !== 1'b1 || bus_d !== exp_b) begin
                miscompares++;
                $display("FAIL contention_data g%0d: v=%b d=%h, expected 1/%h", g, bus_v, bus_d, exp_b);
            end
            req[g % 4] = 1'b0;
            tick();
            if (g < 4) req[g % 4] = 1'b1;
            else       req = 4'b0000;
        end
        tick();
        tick();
    endtask

    task automatic test_pointer_wrap();
        din = 32'hD0C0B0A0;
        req = 4'b1000;
        tick();
        vectors++;
        if (gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL wrap_owner3: got %b, expected 1000", gnt);
        end
        tick();
        req = 4'b0000;
        tick();
        tick();
        req = 4'b0101;
        tick();
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL wrap_to_0: got %b, expected 0001", gnt);
        end
        tick();
        req = 4'b0100;
        tick();
        req = 4'b0101;
        tick();
        tick();
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL wrap_0_vs_2: got %b, expected 0100", gnt);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_burst();
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        rst_n = 1'b1;
        req   = 4'b0011;
        din   = 32'h00002010;
        tick();
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL burst_first_grant: got %b, expected 0001", gnt);
        end
`ifdef BUS8_ARB_BURST_LIMIT_EN
        begin
            int nv = 0;
            int nz = 0;
            bit found = 1'b0;
            for (int c = 0; c < 12 && !found; c++) begin
                tick();
                if (bus_v === 1'b1) begin
                    nv++;
                    vectors++;
                    if (bus_d !== 8'h10) begin
                        miscompares++;
                        $display("FAIL burst_data c%0d: got %h, expected 10", c, bus_d);
                    end
                end
                if (gnt === 4'b0000) nz++;
                if (gnt === 4'b0010) found = 1'b1;
            end
            vectors++;
            if (nv != TB_BURST) begin
                miscompares++;
                $display("FAIL burst_count: got %0d, expected %0d", nv, TB_BURST);
            end
            vectors++;
            if (!found || nz != 2) begin
                miscompares++;
                $display("FAIL burst_handover: found=%0d gaps=%0d, expected 1/2", found, nz);
            end
        end
`else
        for (int c = 0; c < 24; c++) begin
            tick();
            vectors++;
            if (gnt !== 4'b0001 || bus_v !== 1'b1 || bus_d !== 8'h10) begin
                miscompares++;
                $display("FAIL unlimited_grant c%0d: gnt=%b v=%b d=%h, expected 0001/1/10", c, gnt, bus_v, bus_d);
            end
        end
`endif
        req = 4'b0000;
        tick();
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL burst_cleanup: busy=%b gnt=%b, expected 0/0000", busy, gnt);
        end
    endtask

    task automatic test_random();
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (req[b]) req[b] = ($urandom_range(0, 7) != 0);
                else        req[b] = ($urandom_range(0, 3) == 0);
            end
            din   = $urandom();
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random c%0d: got %h, expected %h (req=%b)", c, dut_vec, exp_vec, req);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_pointer_wrap();
        test_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
